// File: rtl/radar_pio_in_edge.sv
// Avalon-MM input PIO: two-flop synchroniser, per-bit debounce, sticky W1C edge
// capture and a maskable registered level interrupt.
module radar_pio_in_edge #(
   parameter int WIDTH     = 16,
   parameter int EDGE_TYPE = 0,
   parameter int DEBOUNCE  = 1,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic             irq
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);

   logic [WIDTH-1:0] s1_q, s2_q;
   logic [WIDTH-1:0] filt_q, filt_d;
   logic [WIDTH-1:0] irqmask_q, irqmask_d;
   logic [WIDTH-1:0] edgecap_q, edgecap_d;
   logic [CNT_W-1:0] cnt_q [WIDTH];
   logic [CNT_W-1:0] cnt_d [WIDTH];
   logic [31:0]      readdata_q, readdata_d;
   logic             irq_q, irq_d;

   logic [WIDTH-1:0] rise, fall, edge_ev, clr;
   logic             wr_en;
   logic             unused_wd;

   // Write bits above WIDTH have no register behind them.
   assign unused_wd = ^writedata;

   always_comb begin
      filt_d = filt_q;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_d[i] = '0;
         if (s2_q[i] != filt_q[i]) begin
            if (cnt_q[i] == CNT_MAX) filt_d[i] = s2_q[i];
            else                     cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end
   end

   always_comb begin
      rise    = filt_d & ~filt_q;
      fall    = ~filt_d & filt_q;
      edge_ev = (EDGE_TYPE == 0) ? rise : (EDGE_TYPE == 1) ? fall : (rise | fall);

      wr_en = chipselect & ~write_n;
      clr   = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

      // A new event on a bit overrides a clear of that bit in the same cycle.
      edgecap_d = (edgecap_q & ~clr) | edge_ev;
      irqmask_d = (wr_en && address == 2'd2) ? writedata[WIDTH-1:0] : irqmask_q;
      irq_d     = |(edgecap_q & irqmask_q);

      readdata_d = '0;
      case (address)
         2'd0:    readdata_d = 32'(filt_q);
         2'd2:    readdata_d = 32'(irqmask_q);
         2'd3:    readdata_d = 32'(edgecap_q);
         default: readdata_d = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_q       <= '0;
         s2_q       <= '0;
         filt_q     <= '0;
         irqmask_q  <= '0;
         edgecap_q  <= '0;
         readdata_q <= '0;
         irq_q      <= 1'b0;
         for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      end else begin
         s1_q       <= in_port;
         s2_q       <= s1_q;
         filt_q     <= filt_d;
         irqmask_q  <= irqmask_d;
         edgecap_q  <= edgecap_d;
         readdata_q <= readdata_d;
         irq_q      <= irq_d;
         for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   assign readdata = readdata_q;
   assign irq      = irq_q;

endmodule
